// File: rtl/ring_counter.sv
// ring_counter
//   Parametrised ring / Johnson counter with parallel load, selectable
//   rotation mode and a programmable step prescaler. It drives one-hot or
//   thermometer select patterns into downstream sequencing logic.
//
// Parameters
//   WIDTH     counter width (minimum 2)
//   RESET_VAL value of count after reset
//   DIV_W     prescaler width
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   load   in   synchronous parallel load of data (beats any step)
//   data   in   load value, WIDTH bits
//   mod    in   00 hold, 01 rotate left, 10 rotate right, 11 Johnson
//   en     in   prescaler / step enable
//   div    in   step period minus one
//   count  out  counter value (registered)
//   step   out  one-cycle pulse when a newly stepped count first appears
//   wrap   out  one-cycle pulse, with step, when a full period completes
module ring_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               DIV_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mod,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap
);

  // Wide enough to hold the Johnson period value 2*WIDTH itself.
  localparam int POS_W = $clog2(2 * WIDTH + 1);
  localparam logic [POS_W-1:0] PER_ROT = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] PER_JOH = POS_W'(2 * WIDTH);

  logic [DIV_W-1:0] presc_r;
  logic [POS_W-1:0] pos_r;
  logic [1:0]       last_mod_r;

  logic             active_s;
  logic             tick_s;
  logic             change_s;
  logic [POS_W-1:0] period_s;
  logic [POS_W-1:0] base_s;
  logic [POS_W-1:0] pos_inc_s;
  logic             wrap_s;

  // Next counter pattern for the selected mode.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                  input logic [1:0]       m);
    logic [WIDTH-1:0] n;
    case (m)
      2'b01:   n = {c[WIDTH-2:0], c[WIDTH-1]};
      2'b10:   n = {c[0], c[WIDTH-1:1]};
      2'b11:   n = {c[WIDTH-2:0], ~c[WIDTH-1]};
      default: n = c;
    endcase
    return n;
  endfunction

  // Tick, mode-change and period-completion decode.
  always_comb begin
    active_s  = (mod != 2'b00);
    tick_s    = en && active_s && (presc_r >= div);
    // last_mod remembers the last active mode, so passing through hold
    // (00) never looks like a mode change; the very first activation out
    // of reset (last_mod = 00) does not either, and pos is 0 there anyway.
    change_s  = en && active_s && (last_mod_r != 2'b00) && (mod != last_mod_r);
    period_s  = (mod == 2'b11) ? PER_JOH : PER_ROT;
    // A step in a mode-change cycle is step 1 of the new origin.
    base_s    = change_s ? {POS_W{1'b0}} : pos_r;
    pos_inc_s = base_s + POS_W'(1);
    wrap_s    = !change_s && (pos_inc_s >= period_s);
  end

  // Counter, prescaler, position and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= RESET_VAL;
      step       <= 1'b0;
      wrap       <= 1'b0;
      presc_r    <= {DIV_W{1'b0}};
      pos_r      <= {POS_W{1'b0}};
      last_mod_r <= 2'b00;
    end else begin
      if (en && active_s) begin
        last_mod_r <= mod;
      end else begin
        last_mod_r <= last_mod_r;
      end

      if (load) begin
        // A tick coinciding with load is discarded.
        count   <= data;
        presc_r <= {DIV_W{1'b0}};
        pos_r   <= {POS_W{1'b0}};
        step    <= 1'b0;
        wrap    <= 1'b0;
      end else if (tick_s) begin
        count   <= next_count(count, mod);
        presc_r <= {DIV_W{1'b0}};
        pos_r   <= wrap_s ? {POS_W{1'b0}} : pos_inc_s;
        step    <= 1'b1;
        wrap    <= wrap_s;
      end else begin
        count   <= count;
        step    <= 1'b0;
        wrap    <= 1'b0;
        if (en && active_s) begin
          presc_r <= presc_r + DIV_W'(1);
        end else begin
          presc_r <= presc_r;
        end
        if (change_s) begin
          pos_r <= {POS_W{1'b0}};
        end else begin
          pos_r <= pos_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter (WIDTH=4, RESET_VAL=0001, DIV_W=8).
// Table of {inputs, expected outputs} records plus hand-written sequences
// for mode change, hold and asynchronous reset.
module tb_ring_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] data;
  logic [1:0] mod;
  logic       en;
  logic [7:0] div;
  logic [3:0] count;
  logic       step;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic [1:0] m;
    logic       e;
    logic [7:0] dv;
    logic [3:0] c;
    logic       s;
    logic       w;
  } vec_t;

  typedef struct {
    logic [3:0] c;
    logic       s;
    logic       w;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  ring_counter #(.WIDTH(4), .RESET_VAL(4'b0001), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .mod(mod),
    .en(en), .div(div), .count(count), .step(step), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic add(input logic ld, input logic [3:0] d, input logic [1:0] m,
                     input logic e, input logic [7:0] dv,
                     input logic [3:0] c, input logic s, input logic w);
    vec_t v;
    v.ld = ld; v.d = d; v.m = m; v.e = e; v.dv = dv; v.c = c; v.s = s; v.w = w;
    vecs.push_back(v);
  endtask

  // Drive one cycle on the falling edge, queue the expectation, compare after the edge.
  task automatic apply(input logic ld, input logic [3:0] d, input logic [1:0] m,
                       input logic e, input logic [7:0] dv,
                       input logic [3:0] c, input logic s, input logic w,
                       input string tag);
    exp_t x;
    @(negedge clk);
    load = ld; data = d; mod = m; en = e; div = dv;
    x.c = c; x.s = s; x.w = w; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".count"}, count, x.c);
    check({x.tag, ".step"}, {3'b000, step}, {3'b000, x.s});
    check({x.tag, ".wrap"}, {3'b000, wrap}, {3'b000, x.w});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data = 4'b0000; mod = 2'b00; en = 1'b0; div = 8'd0;
    #1;
    check("reset0.count", count, 4'b0001);
    check("reset0.step", {3'b000, step}, 4'b0000);
    check("reset0.wrap", {3'b000, wrap}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Rotate left, one step per clock.
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b1);
    // Load 1000, then rotate right with div=2: steps at edges 3,6,9,12.
    add(1'b1, 4'b1000, 2'b00, 1'b0, 8'd2, 4'b1000, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] c;
      case ((k - 1) / 3)
        0:       c = (k == 3)  ? 4'b0100 : 4'b1000;
        1:       c = (k == 6)  ? 4'b0010 : 4'b0100;
        2:       c = (k == 9)  ? 4'b0001 : 4'b0010;
        default: c = (k == 12) ? 4'b1000 : 4'b0001;
      endcase
      add(1'b0, 4'b0000, 2'b10, 1'b1, 8'd2, c, (k % 3) == 0, k == 12);
    end
    // Johnson from 0000: wrap only on the 8th step.
    add(1'b1, 4'b0000, 2'b00, 1'b0, 8'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b0011, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b0111, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b1111, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b1110, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b1100, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b11, 1'b1, 8'd0, 4'b0000, 1'b1, 1'b1);
    // Load versus tick, div=1.
    add(1'b1, 4'b0011, 2'b01, 1'b1, 8'd1, 4'b0011, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd1, 4'b0011, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd1, 4'b0110, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd1, 4'b0110, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 2'b01, 1'b1, 8'd1, 4'b1010, 1'b0, 1'b0);  // tick discarded
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd1, 4'b1010, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd1, 4'b0101, 1'b1, 1'b0);
    // Raise div, then drop it below presc: immediate tick.
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd3, 4'b0101, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd3, 4'b0101, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b1010, 1'b1, 1'b0);
    // en=0 freezes, then the period completes on the 4th step since load.
    add(1'b0, 4'b0000, 2'b01, 1'b0, 8'd0, 4'b1010, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b0, 8'd0, 4'b1010, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0101, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b1010, 1'b1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ld, vecs[i].d, vecs[i].m, vecs[i].e, vecs[i].dv,
            vecs[i].c, vecs[i].s, vecs[i].w, $sformatf("vec%0d", i));
    end

    // Mode change: two left steps, then right; wrap only after 4 right steps.
    apply(1'b1, 4'b0001, 2'b01, 1'b1, 8'd0, 4'b0001, 1'b0, 1'b0, "mc_load");
    apply(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0010, 1'b1, 1'b0, "mc_l1");
    apply(1'b0, 4'b0000, 2'b01, 1'b1, 8'd0, 4'b0100, 1'b1, 1'b0, "mc_l2");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0010, 1'b1, 1'b0, "mc_r1");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b0, "mc_r2");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b0, "mc_r3");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0100, 1'b1, 1'b1, "mc_r4");
    // Hold for 5 cycles mid-period; wrap timing unaffected on resume.
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0010, 1'b1, 1'b0, "hd_r1");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b0, "hd_r2");
    for (int h = 0; h < 5; h++) begin
      apply(1'b0, 4'b0000, 2'b00, 1'b1, 8'd0, 4'b0001, 1'b0, 1'b0, $sformatf("hold%0d", h));
    end
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b0, "hd_r3");
    apply(1'b0, 4'b0000, 2'b10, 1'b1, 8'd0, 4'b0100, 1'b1, 1'b1, "hd_r4");

    // Asynchronous reset between edges, while step/wrap are high.
    @(negedge clk);
    en = 1'b0; mod = 2'b00;
    #2 reset = 1'b1;
    #1;
    check("areset.count", count, 4'b0001);
    check("areset.step", {3'b000, step}, 4'b0000);
    check("areset.wrap", {3'b000, wrap}, 4'b0000);
    #1 reset = 1'b0;
    // No pulse on release; first step at edge D+1 with div=2.
    apply(1'b0, 4'b0000, 2'b01, 1'b1, 8'd2, 4'b0001, 1'b0, 1'b0, "rel1");
    apply(1'b0, 4'b0000, 2'b01, 1'b1, 8'd2, 4'b0001, 1'b0, 1'b0, "rel2");
    apply(1'b0, 4'b0000, 2'b01, 1'b1, 8'd2, 4'b0010, 1'b1, 1'b0, "rel3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_counter.md
# ring_counter

Parametrised ring/Johnson counter with parallel load, selectable rotation mode, and a programmable step prescaler. It is the generalised successor of the team's fixed 4-bit load/reset/rotate counter and adds arbitrary width, a Johnson mode, a hold mode, rate control and cycle-completion pulses. It sits in stimulus/sequencing logic and drives one-hot or thermometer select patterns into downstream modules.

## Interface
- `WIDTH`, 4: counter width; minimum 2.
- `RESET_VAL`, 1: value of `count` after reset, WIDTH bits.
- `DIV_W`, 8: prescaler width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  synchronous parallel load of `data`.
- `data`  in  WIDTH  load value.
- `mod`  in  2  mode select:
  - 00: hold.
  - 01: rotate left, `{count[W-2:0], count[W-1]}`.
  - 10: rotate right, `{count[0], count[W-1:1]}`.
  - 11: Johnson, `{count[W-2:0], ~count[W-1]}`.
- `en`  in  1  prescaler/step enable.
- `div`  in  DIV_W  step period minus one.
- `count`  out  WIDTH  counter value.
- `step`  out  1  registered 1-cycle pulse, high in the cycle a new stepped `count` first appears.
- `wrap`  out  1  registered 1-cycle pulse, high with `step` when the step completes a full period.

## Operation
- Internal state:
  - `presc` (DIV_W bits).
  - `pos`: step index since the last origin, range 0..2*WIDTH-1.
  - `last_mod` (2 bits).
- Active mode means `mod != 00`.
- Tick: `en=1`, mode active, and `presc >= div`.
  - On a tick, `presc` returns to 0.
  - Otherwise, if `en=1` and the mode is active, `presc` increments.
  - Otherwise `presc` holds.
- Step: on a tick, `count` takes the `mod` transform and `pos` advances.
  - `pos` period is WIDTH for `mod` 01/10 and 2*WIDTH for `mod` 11.
  - `pos` wraps to 0 at the end of its period, and `wrap` asserts on that step.
  - For any start value, `count` then equals its value at the origin.
- Mode change: when `mod` changes to a different active value (compared against `last_mod`), `pos` clears to 0 and no `wrap` is produced.
  - A step still occurs in that cycle if a tick fires; that step counts as `pos`=1 of the new origin.
  - Transitions into or out of 00 do not clear `pos`.
- Priority, highest first: `reset` > `load` > step > hold.
  - `load`: `count` <= `data`, and `presc`, `pos`, `step`, `wrap` <= 0.
  - A simultaneous tick is discarded.
- `div` is sampled every cycle. Lowering `div` below the current `presc` forces a tick on the next enabled cycle; it never waits for `presc` to overflow.
- `en=0` freezes `presc` and `pos`, and `count` holds.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `count`=RESET_VAL, `step`=0, `wrap`=0.
  - `presc`=0, `pos`=0, `last_mod`=00.
- With `div`=D, `en`=1 and the mode constant, steps occur every D+1 cycles.
  - First step: edge D+1 after `en` rises, or after `load`/reset release.
- `div`=0 gives one step per clock.
- `count`, `step` and `wrap` change only on clock edges, except for the asynchronous reset.
- `step`/`wrap` are high for exactly one cycle per event, including back-to-back steps at `div`=0.
- `load` is visible on `count` one edge after it is sampled.
- `reset` asserted mid-prescale or mid-period: immediate return to reset values. No pulse is emitted on release.

## Test plan
- Reset: WIDTH=4, RESET_VAL=0001, pulse `reset` between edges -> `count`=0001, `step`=`wrap`=0 immediately, before any clock.
- Rotate left: `mod`=01, `div`=0, `en`=1 -> `count` 0010, 0100, 1000, 0001 on consecutive edges; `step` high all 4 cycles; `wrap` high only with 0001.
- Rotate right with prescale: `mod`=10, `div`=2, start 1000 -> 0100 at edge 3, 0010 at edge 6, 0001 at edge 9, 1000 at edge 12 with `wrap`=1; `step` low on the other edges.
- Johnson: `load` 0000, `mod`=11, `div`=0 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; `wrap` only on the 8th.
- Load vs tick: `load`=1, `data`=1010 on a tick edge -> `count`=1010, `step`=`wrap`=0; next step follows D+1 cycles later.
- Mode change: rotate left 2 steps, switch to `mod`=10 -> `pos` restarts; `wrap` appears only after 4 right steps. Hold (00) for 5 cycles mid-run -> `count` frozen; `wrap` timing unchanged after resuming.
